instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the number of consecutive unanswered request cycles that counts as a fetch fault (range 1..255).
REQ-002 Parameter IRQ_VECTOR, default 32'h0000_0080, SHALL be the interrupt redirect address.
REQ-003 clock  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 pc  input  32  SHALL carry the current program counter value.
REQ-006 next_address  output  32  SHALL carry the next program counter value (combinational), fed back to the PC register each clock.
REQ-007 imem_req  output  1 / imem_addr  output  32  SHALL form the instruction memory read request.
REQ-008 imem_ready  input  1 / imem_rdata  input  32  SHALL form the memory response; data valid when imem_ready=1.
REQ-009 redirect  input  1 / redirect_target  input  32  SHALL carry branch/jump redirects from execute.
REQ-010 id_ready  input  1  SHALL indicate decode accepts the output word this cycle.
REQ-011 if_valid  output  1 / if_instr  output  32 / if_pc  output  32  SHALL form the registered output to decode.
REQ-012 fetch_error  output  1  SHALL flag a sticky timeout fault.
REQ-013 interrupt  input  1 / irq_epc  output  32  SHALL exist in every build; behaviour set by REQ-030/031.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, ERROR; IDLE -> WAIT unconditionally on the first clock after reset.
REQ-015 imem_req SHALL be 1 only in WAIT with (if_valid=0 or id_ready=1); imem_addr SHALL equal pc at all times.
REQ-016 Accept SHALL mean imem_req=1 and imem_ready=1 and redirect=0; on accept, if_instr<=imem_rdata, if_pc<=pc, if_valid<=1.
REQ-017 Transfer to decode SHALL occur when if_valid=1 and id_ready=1; if_valid SHALL clear after transfer unless a new accept occurs in the same cycle.
REQ-018 next_address priority SHALL be: redirect -> {redirect_target[31:2],2'b00}; else accept -> pc+4; else pc.
REQ-019 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 Redirect in IDLE/WAIT SHALL clear if_valid next cycle, discard any same-cycle memory response, clear the timeout counter, and leave the FSM in WAIT.
REQ-021 Misaligned redirect_target bits [1:0] SHALL be ignored (forced to 00).
REQ-022 Timeout counter SHALL increment each cycle imem_req=1 and imem_ready=0, clear on accept, redirect or imem_req=0.
REQ-023 Counter reaching TIMEOUT_CYCLES SHALL move FSM to ERROR on that edge.
REQ-024 ERROR: imem_req=0, fetch_error=1, if_valid=0, next_address=pc; redirect and interrupt ignored; exit only via reset.
REQ-025 Throughput with imem_ready tied 1 and id_ready tied 1 SHALL be one instruction per cycle.
REQ-026 imem_ready while imem_req=0 SHALL be ignored.

Reset
REQ-027 While reset=1: state IDLE, counter 0, if_valid 0, if_instr 0, if_pc 0, fetch_error 0, irq_epc 0, imem_req 0, next_address=pc.
REQ-028 Reset asserted mid-request SHALL abandon the request with no output update.
REQ-029 First request SHALL issue on the second clock after reset deasserts.

Configuration
REQ-030 With FETCH_IRQ_EN defined: interrupt=1 with redirect=0 in WAIT SHALL act as a redirect to IRQ_VECTOR (same flush rules as REQ-020), and irq_epc<=pc on that edge; interrupt is level-sampled, one redirect per cycle asserted.
REQ-031 Without FETCH_IRQ_EN: interrupt SHALL be ignored and irq_epc SHALL be constant 0.

Verification
REQ-032 pc=0, imem_ready=1, id_ready=1 for 4 cycles -> next_address 4,8,12,16; if_pc 0,4,8 on successive cycles; imem_rdata captured per word.
REQ-033 id_ready=0 with if_valid=1 -> imem_req=0, next_address=pc, if_instr held; id_ready=1 -> fetch resumes with no lost/duplicated word.
REQ-034 redirect=1, target 32'h0000_0103, same cycle imem_ready=1 -> next_address=32'h0000_0100, response discarded, if_valid=0 next cycle.
REQ-035 imem_ready=0 for 15 cycles (default) -> fetch_error=1, imem_req=0; redirect ignored; reset clears.
REQ-036 pc=32'hFFFF_FFFC accept -> next_address=0.
REQ-037 FETCH_IRQ_EN build, interrupt=1 at pc=32'h40 -> next_address=32'h80, irq_epc=32'h40; non-macro build -> no effect, irq_epc=0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus: memory read request/response plus the registered word handed to decode.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ready, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ready, imem_rdata, id_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding memory read, redirect flush, sticky timeout fault.
// Optional interrupt redirect to IRQ_VECTOR is enabled by defining FETCH_IRQ_EN.
module instruction_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [31:0] IRQ_VECTOR     = 32'h0000_0080
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                pc,
  output logic [31:0]                next_address,
  instruction_fetch_if.master        fetch,
  input  logic                       redirect,
  input  logic [31:0]                redirect_target,
  output logic                       fetch_error,
  input  logic                       interrupt,
  output logic [31:0]                irq_epc
);

  typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic [7:0]  count;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        imem_req;
  logic        accept;
  logic        flush;
  logic        take_redirect;
  logic        irq_take;
  logic        timeout_hit;
  logic        transfer;

  assign fetch.imem_req  = imem_req;
  assign fetch.imem_addr = pc;
  assign fetch.if_valid  = if_valid;
  assign fetch.if_instr  = if_instr;
  assign fetch.if_pc     = if_pc;
  assign fetch_error     = (state == ERROR);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Combinational outputs are gated by reset so the stage is silent for the whole reset window.
  always_comb begin
    state_next    = state;
    imem_req      = 1'b0;
    accept        = 1'b0;
    take_redirect = 1'b0;
    irq_take      = 1'b0;
    flush         = 1'b0;
    timeout_hit   = 1'b0;
    transfer      = 1'b0;
    next_address  = pc;

    if (!reset) begin
      take_redirect = redirect && (state != ERROR);
`ifdef FETCH_IRQ_EN
      irq_take      = interrupt && !redirect && (state == WAIT);
`else
      irq_take      = 1'b0 & interrupt;
`endif
      flush         = take_redirect || irq_take;
      imem_req      = (state == WAIT) && (!if_valid || fetch.id_ready);
      accept        = imem_req && fetch.imem_ready && !flush;
      transfer      = if_valid && fetch.id_ready;
      timeout_hit   = imem_req && !fetch.imem_ready && !flush &&
                      (count == TIMEOUT_LIMIT - 8'd1);

      if (flush)
        next_address = take_redirect ? (redirect_target & ~32'h0000_0003) : IRQ_VECTOR;
      else if (accept)
        next_address = pc + 32'd4;
    end

    unique case (state)
      IDLE:    state_next = WAIT;
      WAIT:    if (timeout_hit) state_next = ERROR;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      if (imem_req && !fetch.imem_ready && !flush)
        count <= count + 8'd1;
      else
        count <= '0;

      if (flush || state_next == ERROR)
        if_valid <= 1'b0;
      else if (accept)
        if_valid <= 1'b1;
      else if (transfer)
        if_valid <= 1'b0;

      if (accept) begin
        if_instr <= fetch.imem_rdata;
        if_pc    <= pc;
      end
    end
  end

`ifdef FETCH_IRQ_EN
  always_ff @(posedge clock) begin
    if (reset)         irq_epc <= '0;
    else if (irq_take) irq_epc <= pc;
  end
`else
  assign irq_epc = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus pushes expected decode words, a negedge monitor pops them.
module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_address;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fetch_error;
  logic        interrupt;
  logic [31:0] irq_epc;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .TIMEOUT_CYCLES (15),
    .IRQ_VECTOR     (32'h0000_0080)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pc              (pc),
    .next_address    (next_address),
    .fetch           (bus),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_error     (fetch_error),
    .interrupt       (interrupt),
    .irq_epc         (irq_epc)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } xfer_t;
  xfer_t expq[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p);
    xfer_t x;
    x.pc    = p;
    x.instr = mem_word(p);
    expq.push_back(x);
  endtask

  // PC register owned by the bench, loaded from next_address each edge.
  task automatic tick();
    logic [31:0] na;
    na = next_address;
    @(posedge clock);
    #1;
    pc = reset ? 32'h0 : na;
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset && bus.if_valid === 1'b1 && bus.id_ready === 1'b1) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL xfer_unexpected: got pc %h instr %h expected none", bus.if_pc, bus.if_instr);
      end else begin
        xfer_t e;
        e = expq.pop_front();
        chk("xfer_pc", bus.if_pc, e.pc);
        chk("xfer_instr", bus.if_instr, e.instr);
      end
    end
  end

  initial begin
    logic [31:0] exp_na [4];
    exp_na[0] = 32'd4;  exp_na[1] = 32'd8;  exp_na[2] = 32'd12; exp_na[3] = 32'd16;

    reset = 1'b1; pc = '0; redirect = 1'b1; redirect_target = 32'h0000_0400;
    interrupt = 1'b0; bus.imem_ready = 1'b1; bus.id_ready = 1'b1;
    tick(); tick();
    chk("rst_next_address", next_address, 32'h0);
    chk("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_fetch_error", {31'b0, fetch_error}, 32'h0);
    chk("rst_irq_epc", irq_epc, 32'h0);

    // First cycle out of reset is IDLE: no request yet.
    reset = 1'b0; redirect = 1'b0; #1;
    chk("idle_imem_req", {31'b0, bus.imem_req}, 32'h0);
    tick();
    chk("wait_imem_req", {31'b0, bus.imem_req}, 32'h1);
    chk("imem_addr", bus.imem_addr, 32'h0);

    // Streaming fetch, one word per cycle.
    for (int i = 0; i < 4; i++) begin
      chk("stream_next_address", next_address, exp_na[i]);
      push(pc);
      tick();
    end
    chk("stream_if_pc", bus.if_pc, 32'd12);

    // Decode stall: request dropped, word held, memory ready ignored.
    bus.id_ready = 1'b0; #1;
    chk("stall_imem_req", {31'b0, bus.imem_req}, 32'h0);
    chk("stall_next_address", next_address, 32'd16);
    tick(); tick();
    chk("stall_if_instr", bus.if_instr, mem_word(32'd12));
    chk("stall_pc", pc, 32'd16);
    bus.id_ready = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      push(pc);
      tick();
    end
    chk("resume_pc", pc, 32'd24);
    bus.imem_ready = 1'b0; #1;
    chk("noresp_next_address", next_address, 32'd24);
    tick();
    chk("drain_if_valid", {31'b0, bus.if_valid}, 32'h0);

    // Misaligned redirect with same-cycle response: response dropped.
    redirect = 1'b1; redirect_target = 32'h0000_0103; bus.imem_ready = 1'b1; #1;
    chk("redir_next_address", next_address, 32'h0000_0100);
    tick();
    chk("redir_if_valid", {31'b0, bus.if_valid}, 32'h0);
    redirect = 1'b0;

    // Redirect flushes a held word that decode never took.
    bus.id_ready = 1'b0; #1;
    tick();
    chk("held_if_valid", {31'b0, bus.if_valid}, 32'h1);
    redirect = 1'b1; redirect_target = 32'h0000_0200; #1;
    chk("flush_next_address", next_address, 32'h0000_0200);
    tick();
    chk("flush_if_valid", {31'b0, bus.if_valid}, 32'h0);

    // PC wrap.
    redirect_target = 32'hFFFF_FFFE; #1;
    tick();
    redirect = 1'b0; bus.id_ready = 1'b1; #1;
    chk("wrap_next_address", next_address, 32'h0);
    push(32'hFFFF_FFFC);
    tick();
    bus.imem_ready = 1'b0;

    // Interrupt at pc 0x40.
    redirect = 1'b1; redirect_target = 32'h0000_0040; #1;
    tick();
    redirect = 1'b0; interrupt = 1'b1; bus.imem_ready = 1'b1; #1;
`ifdef FETCH_IRQ_EN
    chk("irq_next_address", next_address, 32'h0000_0080);
    tick();
    chk("irq_epc", irq_epc, 32'h0000_0040);
    chk("irq_if_valid", {31'b0, bus.if_valid}, 32'h0);
`else
    chk("irq_next_address", next_address, 32'h0000_0044);
    push(32'h0000_0040);
    tick();
    chk("irq_epc", irq_epc, 32'h0);
`endif
    interrupt = 1'b0;

    // Timeout after 15 unanswered request cycles.
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("pre_timeout_fetch_error", {31'b0, fetch_error}, 32'h0);
    tick();
    chk("timeout_fetch_error", {31'b0, fetch_error}, 32'h1);
    chk("timeout_imem_req", {31'b0, bus.imem_req}, 32'h0);

    // ERROR ignores redirect, interrupt and memory.
    redirect = 1'b1; redirect_target = 32'h0000_0300; interrupt = 1'b1; bus.imem_ready = 1'b1; #1;
    chk("error_next_address", next_address, pc);
    chk("error_imem_req", {31'b0, bus.imem_req}, 32'h0);
    tick();
    chk("error_sticky", {31'b0, fetch_error}, 32'h1);
    chk("error_if_valid", {31'b0, bus.if_valid}, 32'h0);
    redirect = 1'b0; interrupt = 1'b0;

    // Reset clears, then a request abandoned by reset leaves outputs untouched.
    reset = 1'b1; tick();
    chk("reset_clears_error", {31'b0, fetch_error}, 32'h0);
    reset = 1'b0; tick(); tick();
    chk("rewait_imem_req", {31'b0, bus.imem_req}, 32'h1);
    reset = 1'b1; #1;
    chk("midreq_imem_req", {31'b0, bus.imem_req}, 32'h0);
    tick();
    chk("midreq_if_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("midreq_if_pc", bus.if_pc, 32'h0);
    tick();

    chk("scoreboard_empty", expq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
